// File: rtl/fusion_accum_unit.sv
// Purpose: sums NUM_PP partial products per beat, shifts the sum, and accumulates a group result.
// Latency: a last beat accepted at edge t presents its group result after edge t+2.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready; otherwise one beat per cycle.
//
// Ports:
//   clk, rst                      sole clock (rising edge), synchronous active-high reset
//   in_valid/in_ready             beat handshake; in_ready is low during reset and while stalled
//   in_pp                         NUM_PP lanes of PP_WIDTH bits, lane i at [i*PP_WIDTH +: PP_WIDTH]
//   in_shift                      left shift applied to this beat's lane sum
//   in_sign                       signed group flag, only honoured on beats with in_first
//   in_first, in_last             group delimiters (both set = single-beat group)
//   out_valid/out_ready           result handshake
//   out_acc, out_count            group total and beat count (count saturates at all-ones)
module fusion_accum_unit #(
  parameter int NUM_PP      = 4,
  parameter int PP_WIDTH    = 10,
  parameter int SHIFT_WIDTH = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int COUNT_WIDTH = 8,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_PP*PP_WIDTH-1:0]    in_pp,
  input  logic [SHIFT_WIDTH-1:0]        in_shift,
  input  logic                          in_sign,
  input  logic                          in_first,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_acc,
  output logic [COUNT_WIDTH-1:0]        out_count
);

  // Lane sum width: one extra bit beyond the carry growth keeps an unsigned
  // sum non-negative when it is later treated as a two's-complement value.
  localparam int LOG_PP    = $clog2(NUM_PP);
  localparam int SUM_W     = PP_WIDTH + LOG_PP + 1;
  localparam int MAX_SHIFT = (1 << SHIFT_WIDTH) - 1;
  localparam int TERM_W    = SUM_W + MAX_SHIFT;
  // Accumulation width: wide enough that base + term can never overflow,
  // so wrap and clamp decisions are made on the exact result.
  localparam int EXT_W     = ((TERM_W > ACC_WIDTH) ? TERM_W : ACC_WIDTH) + 2;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic stall;
  logic accept;
  logic group_sign;
  logic eff_sign;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !rst && !stall;
  assign accept   = in_valid && in_ready;
  assign eff_sign = in_first ? in_sign : group_sign;

  // ---------------------------------------------------------------------------
  // Stage 1: extend and sum the lanes
  // ---------------------------------------------------------------------------
  function automatic logic [SUM_W-1:0] extend_lane(input logic [PP_WIDTH-1:0] lane,
                                                   input logic                sgn);
    return {{(SUM_W-PP_WIDTH){sgn & lane[PP_WIDTH-1]}}, lane};
  endfunction

  logic [SUM_W-1:0] pp_sum;

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      pp_sum = pp_sum + extend_lane(in_pp[i*PP_WIDTH +: PP_WIDTH], eff_sign);
    end
  end

  logic                   s1_vld;
  logic [SUM_W-1:0]       s1_sum;
  logic [SHIFT_WIDTH-1:0] s1_shift;
  logic                   s1_first;
  logic                   s1_last;
  logic                   s1_sign;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_sum     <= '0;
      s1_shift   <= '0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_sign    <= 1'b0;
      group_sign <= 1'b0;
    end else if (!stall) begin
      s1_vld <= accept;
      if (accept) begin
        s1_sum   <= pp_sum;
        s1_shift <= in_shift;
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_sign  <= eff_sign;
        if (in_first) begin
          group_sign <= in_sign;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift the sum at full width (no bits lost for any shift amount)
  // ---------------------------------------------------------------------------
  logic [TERM_W-1:0] term_c;

  assign term_c = {{(TERM_W-SUM_W){s1_sum[SUM_W-1]}}, s1_sum} << s1_shift;

  logic              s2_vld;
  logic [TERM_W-1:0] s2_term;
  logic              s2_first;
  logic              s2_last;
  logic              s2_sign;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld   <= 1'b0;
      s2_term  <= '0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sign  <= 1'b0;
    end else if (!stall) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_term  <= term_c;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_sign  <= s1_sign;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: accumulate, then wrap or clamp
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [EXT_W-1:0]       base_ext;
  logic [EXT_W-1:0]       term_ext;
  logic [EXT_W-1:0]       sum_ext;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [EXT_W-ACC_WIDTH:0] sum_hi;

  always_comb begin
    base_ext = '0;
    if (!s2_first) begin
      // The accumulator is interpreted in the group's own signedness.
      base_ext = {{(EXT_W-ACC_WIDTH){s2_sign & acc_q[ACC_WIDTH-1]}}, acc_q};
    end
    // Unsigned terms are non-negative by construction, so sign extension is safe.
    term_ext = {{(EXT_W-TERM_W){s2_term[TERM_W-1]}}, s2_term};
    sum_ext  = base_ext + term_ext;
    sum_hi   = sum_ext[EXT_W-1:ACC_WIDTH-1];
    acc_next = sum_ext[ACC_WIDTH-1:0];

    if (SATURATE) begin
      if (s2_sign) begin
        // Fits in ACC_WIDTH signed only if all bits from the result MSB up agree.
        if (!(&sum_hi) && (|sum_hi)) begin
          acc_next = sum_ext[EXT_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
      end else begin
        if (sum_ext[EXT_W-1]) begin
          acc_next = '0;
        end else if (|sum_ext[EXT_W-2:ACC_WIDTH]) begin
          acc_next = '1;
        end
      end
    end
  end

  always_comb begin
    count_next = COUNT_WIDTH'(1);
    if (!s2_first) begin
      count_next = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
    end else if (!stall) begin
      // Either no result is pending or it is being consumed this cycle, so a
      // completing group can load straight in without a bubble.
      out_valid <= s2_vld && s2_last;
      if (s2_vld) begin
        if (s2_last) begin
          out_acc   <= acc_next;
          out_count <= count_next;
          // Clearing here lets a following beat without first start from zero.
          acc_q     <= '0;
          count_q   <= '0;
        end else begin
          acc_q   <= acc_next;
          count_q <= count_next;
        end
      end
    end
  end

endmodule

// File: doc/fusion_accum_unit.md
# fusion_accum_unit

Parametrised, pipelined successor to the combinational fusion subunit. Each accepted beat carries NUM_PP partial products. The block sums them as signed or unsigned, shifts the sum by a per-beat amount, and accumulates the result across a group of beats delimited by first/last flags. The group total leaves through a valid/ready output with backpressure; the block sits between the bit-brick partial-product array and the output-buffer writeback.

## Interface
- NUM_PP, 4, partial products per beat (≥2)
- PP_WIDTH, 10, width of each partial product
- SHIFT_WIDTH, 4, width of shift amount
- ACC_WIDTH, 32, accumulator/result width
- COUNT_WIDTH, 8, beat-counter width
- SATURATE, 0, 1 = clamp accumulator on overflow, 0 = wrap modulo 2^ACC_WIDTH
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_pp  input  NUM_PP*PP_WIDTH  partial products, lane i at [i*PP_WIDTH +: PP_WIDTH]
- in_shift  input  SHIFT_WIDTH  left shift applied to this beat's sum
- in_sign  input  1  1 = signed group; sampled only on beats with in_first
- in_first  input  1  beat starts a new group (clears accumulator)
- in_last  input  1  beat ends group (result emitted)
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_acc  output  ACC_WIDTH  group result
- out_count  output  COUNT_WIDTH  number of beats in the group, saturating at all-ones

## Operation
- Effective sign per beat: in_sign if in_first, else latched group_sign; group_sign updates on accepted first beats.
- Stage 1 (registered): lanes sign-extended (signed) or zero-extended (unsigned) to SUM_W = PP_WIDTH + clog2(NUM_PP) + 1, then summed. Shift, first, last and sign are carried with the sum.
- Stage 2: term = sum << shift, computed at exact width. base = 0 if first else acc. acc_next = base + term, evaluated at exact width, then:
  - SATURATE=0: truncated to ACC_WIDTH (wrap).
  - SATURATE=1: clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1] when signed, or [0, 2^ACC_WIDTH−1] when unsigned.
- Beat counter: 1 on first, else count+1, saturating.
- On a last beat in stage 2:
  - out_acc ← acc_next, out_count ← count_next, out_valid ← 1.
  - acc and count then reset to 0, so a following beat without first starts from zero and uses the previous group_sign.
- in_first on an open group discards the partial accumulation; no output is produced for the discarded part.
- in_first && in_last on the same beat gives a single-beat result.

## Timing
- Reset (rst high at a clk edge) forces:
  - out_valid=0, out_acc=0, out_count=0
  - acc=0, count=0, group_sign=0
  - all stage valids=0
- in_ready=0 while rst is high; inputs are ignored.
- stall = out_valid && !out_ready. While stall holds, all stages freeze and in_ready=0. Otherwise in_ready=1.
- Latency: a last beat accepted at edge t drives out_valid=1 after edge t+2 (two register stages). Throughput is one beat per cycle without stall.
- out_valid && out_ready with a new last beat completing stage 2 in the same cycle: new result loads and out_valid stays 1, with no bubble.
- out_acc and out_count hold stable while out_valid && !out_ready.
- Reset mid-group or mid-stall: in-flight beats and the pending result are dropped. The first post-reset beat is treated per its flags.

## Test plan
- Unsigned single beat, defaults: pp={4,3,2,1}, shift=2, first=last=1 → out_acc=40, out_count=1, out_valid two cycles after acceptance.
- Signed single beat: all four pp=10'h3FF (−1), shift=3, sign=1 → out_acc=32'hFFFFFFE0, out_count=1.
- Three-beat unsigned group with back-to-back beats: pp all 1, shifts 0/4/8 → single result 1092, out_count=3, no output on intermediate beats.
- Backpressure: out_ready low for 5 cycles with a second group streaming behind → in_ready=0 the cycle after out_valid rises, out_acc stable. The second result (pp all 2, shift 0, single beat → 8) follows immediately after the release handshake.
- SATURATE=1, ACC_WIDTH=16, signed: two-beat group, pp all 511, shift 4 (term 32704 each) → out_acc=16'h7FFF. With SATURATE=0 → out_acc=16'hFF80 (wrapped).
- rst asserted for 1 cycle mid-group (after 2 of 3 beats) → no output. A post-reset beat without first, pp={1,1,1,1}, shift 0, last → out_acc=4, unsigned, out_count=1.
